if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address loaded into the PC on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 inst_adrs  output  32  word address presented to the instruction memory.
REQ-006 inst_in  input  32  instruction returned by the memory, combinationally, in the same cycle.
REQ-007 stall  input  1  downstream hazard; freeze PC and IF/ID.
REQ-008 flush  input  1  squash the IF/ID contents.
REQ-009 br_taken  input  1  redirect fetch to br_target.
REQ-010 br_target  input  32  redirect word address.
REQ-011 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-012 ifid_inst  output  32  registered instruction.
REQ-013 ifid_pc  output  32  word address of ifid_inst.
REQ-014 ifid_pc_next  output  32  ifid_pc + 1.
REQ-015 halted  output  1  high while the state is HALT.
REQ-016 fetch_count  output  16  count of instructions delivered to IF/ID.

Function
REQ-017 The PC SHALL be a word address, and inst_adrs SHALL equal the PC combinationally with zero latency.
REQ-018 The FSM SHALL have two states: RUN and HALT.
REQ-019 Per edge, priority SHALL be br_taken > flush > stall > normal fetch.
REQ-020 On br_taken (any state, stall ignored): PC <= br_target, IF/ID <= bubble, state <= RUN, fetch_count unchanged.
REQ-021 On flush without br_taken: IF/ID <= bubble, PC held (the same address is refetched on the next cycle).
REQ-022 On stall without br_taken or flush: PC, IF/ID, state and fetch_count SHALL hold.
REQ-023 Bubble SHALL be ifid_valid=0, ifid_inst=0, ifid_pc=0, ifid_pc_next=0.
REQ-024 Normal fetch in RUN with inst_in != HALT_WORD: ifid_valid<=1, ifid_inst<=inst_in, ifid_pc<=PC, ifid_pc_next<=PC+1, PC<=PC+1.
REQ-025 Normal fetch in RUN with inst_in == HALT_WORD: IF/ID <= bubble, PC held, state <= HALT.
REQ-026 In HALT without br_taken: PC held, IF/ID <= bubble; flush and stall have no further effect.
REQ-027 PC+1 SHALL wrap modulo 2^32 (32'hFFFF_FFFF -> 0), with no flag raised.
REQ-028 fetch_count SHALL increment by one only on a REQ-024 load, saturating at 16'hFFFF.
REQ-029 halted SHALL be the registered state decode (1 in HALT), asserted the cycle after the halt word is fetched.
REQ-030 The output is a single-cycle fetch: an instruction presented at cycle N appears on ifid_* after edge N.

Reset
REQ-031 Reset SHALL act immediately, without waiting for clk: PC=RESET_PC, IF/ID=bubble, state=RUN, halted=0, fetch_count=0.
REQ-032 Reset asserted mid-operation (including in HALT or during stall) SHALL override all inputs, and no state SHALL change while rst=1.
REQ-033 On the first edge after rst falls, a normal fetch from RESET_PC SHALL occur.

Verification
REQ-034 Sequential fetch: memory words 0..5 are non-halt, no stall -> after 3 edges ifid_pc=2, ifid_pc_next=3, ifid_valid=1, fetch_count=3, inst_adrs=3.
REQ-035 Stall: stall=1 for 2 cycles at PC=4 -> inst_adrs stays 4, ifid_* unchanged, fetch_count unchanged; on release, fetch of word 4 resumes.
REQ-036 Branch with stall and flush all asserted: br_target=32'h10 -> next cycle inst_adrs=32'h10, ifid_valid=0; following edge ifid_pc=32'h10.
REQ-037 Halt: word 6 = 32'hFFFF_FFFF -> halted=1, inst_adrs stays 6, ifid_valid=0 indefinitely; then br_taken with br_target=0 -> halted=0 and fetch resumes at 0.
REQ-038 Wrap and saturation: force PC=32'hFFFF_FFFF via branch -> ifid_pc_next=0 and next inst_adrs=0; run 65540 fetches -> fetch_count=16'hFFFF.
REQ-039 Async reset: pulse rst between edges while valid and halted -> outputs reach reset values before the next edge, and the first post-reset fetch address is RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, its instruction memory and the decode side.
// master = fetch stage; slave = surrounding pipeline / memory model.
interface if_stage_if;
    logic [31:0] inst_adrs;
    logic [31:0] inst_in;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_next;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output inst_adrs,
        input  inst_in,
        input  stall,
        input  flush,
        input  br_taken,
        input  br_target,
        output ifid_valid,
        output ifid_inst,
        output ifid_pc,
        output ifid_pc_next,
        output halted,
        output fetch_count
    );

    modport slave (
        input  inst_adrs,
        output inst_in,
        output stall,
        output flush,
        output br_taken,
        output br_target,
        input  ifid_valid,
        input  ifid_inst,
        input  ifid_pc,
        input  ifid_pc_next,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Single-cycle instruction fetch stage: word-addressed PC, IF/ID register,
// RUN/HALT control and a saturating delivered-instruction counter.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_inst_reg, ifid_inst_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next_reg;
    logic [31:0] ifid_pc_d, ifid_pc_next_d;
    logic [15:0] fetch_count_reg, fetch_count_next;

    logic [31:0] pc_inc;
    logic        is_halt_word;

    // Natural 32-bit overflow gives the required wrap to zero.
    assign pc_inc       = pc_reg + 32'd1;
    assign is_halt_word = (bus.inst_in == HALT_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            pc_reg           <= RESET_PC;
            ifid_valid_reg   <= 1'b0;
            ifid_inst_reg    <= 32'd0;
            ifid_pc_reg      <= 32'd0;
            ifid_pc_next_reg <= 32'd0;
            fetch_count_reg  <= 16'd0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            ifid_valid_reg   <= ifid_valid_next;
            ifid_inst_reg    <= ifid_inst_next;
            ifid_pc_reg      <= ifid_pc_d;
            ifid_pc_next_reg <= ifid_pc_next_d;
            fetch_count_reg  <= fetch_count_next;
        end
    end

    // Priority: branch, then halt residency, then flush, then stall, then fetch.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        ifid_valid_next  = ifid_valid_reg;
        ifid_inst_next   = ifid_inst_reg;
        ifid_pc_d        = ifid_pc_reg;
        ifid_pc_next_d   = ifid_pc_next_reg;
        fetch_count_next = fetch_count_reg;

        if (bus.br_taken) begin
            state_next      = ST_RUN;
            pc_next         = bus.br_target;
            ifid_valid_next = 1'b0;
            ifid_inst_next  = 32'd0;
            ifid_pc_d       = 32'd0;
            ifid_pc_next_d  = 32'd0;
        end else if (state_reg == ST_HALT || bus.flush) begin
            ifid_valid_next = 1'b0;
            ifid_inst_next  = 32'd0;
            ifid_pc_d       = 32'd0;
            ifid_pc_next_d  = 32'd0;
        end else if (bus.stall) begin
            // everything holds via the defaults
        end else if (is_halt_word) begin
            state_next      = ST_HALT;
            ifid_valid_next = 1'b0;
            ifid_inst_next  = 32'd0;
            ifid_pc_d       = 32'd0;
            ifid_pc_next_d  = 32'd0;
        end else begin
            pc_next         = pc_inc;
            ifid_valid_next = 1'b1;
            ifid_inst_next  = bus.inst_in;
            ifid_pc_d       = pc_reg;
            ifid_pc_next_d  = pc_inc;
            if (fetch_count_reg != 16'hFFFF) begin
                fetch_count_next = fetch_count_reg + 16'd1;
            end
        end
    end

    assign bus.inst_adrs    = pc_reg;
    assign bus.ifid_valid   = ifid_valid_reg;
    assign bus.ifid_inst    = ifid_inst_reg;
    assign bus.ifid_pc      = ifid_pc_reg;
    assign bus.ifid_pc_next = ifid_pc_next_reg;
    assign bus.halted       = (state_reg == ST_HALT);
    assign bus.fetch_count  = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized branch/flush/stall/reset
// traffic, every cycle compared against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    if_stage_if bus ();

    if_stage #(.RESET_PC(RST_PC), .HALT_WORD(HALT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // 64-word instruction memory, aliased over the whole address space.
    logic [31:0] mem [0:63];
    assign bus.inst_in = mem[bus.inst_adrs[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_ipcn;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".inst_adrs"}, bus.inst_adrs, m_pc);
        check({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, m_valid});
        check({tag, ".inst"}, bus.ifid_inst, m_inst);
        check({tag, ".pc"}, bus.ifid_pc, m_ipc);
        check({tag, ".pc_next"}, bus.ifid_pc_next, m_ipcn);
        check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, m_halt});
        check({tag, ".count"}, {16'd0, bus.fetch_count}, {16'd0, m_cnt});
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_inst  = 32'd0;
        m_ipc   = 32'd0;
        m_ipcn  = 32'd0;
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_halt = 1'b0;
        m_cnt  = 16'd0;
        model_bubble();
    endtask

    // One clock edge of the fetch stage, written from the behavioural rules.
    task automatic model_edge(input logic b, input logic f, input logic s, input logic [31:0] tgt);
        logic [31:0] word;
        word = mem[m_pc[5:0]];
        if (b) begin
            m_pc   = tgt;
            m_halt = 1'b0;
            model_bubble();
        end else if (m_halt || f) begin
            model_bubble();
        end else if (s) begin
            // frozen
        end else if (word == HALT_W) begin
            m_halt = 1'b1;
            model_bubble();
        end else begin
            m_valid = 1'b1;
            m_inst  = word;
            m_ipc   = m_pc;
            m_ipcn  = m_pc + 32'd1;
            m_pc    = m_pc + 32'd1;
            if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic step(input logic b, input logic f, input logic s, input logic [31:0] tgt,
                        input string tag, input bit show);
        bus.br_taken  = b;
        bus.flush     = f;
        bus.stall     = s;
        bus.br_target = tgt;
        model_edge(b, f, s, tgt);
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (show)
            $display("%s: br=%0b fl=%0b st=%0b tgt=%h -> adrs=%h v=%0b pc=%h inst=%h halt=%0b cnt=%0d",
                     tag, b, f, s, tgt, bus.inst_adrs, bus.ifid_valid, bus.ifid_pc,
                     bus.ifid_inst, bus.halted, bus.fetch_count);
    endtask

    // Asynchronous reset pulse landing between edges; optionally held across one edge.
    task automatic reset_pulse(input bit hold_edge, input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        check_outputs({tag, ".async"});
        if (hold_edge) begin
            bus.br_taken  = 1'b1;
            bus.br_target = 32'h0000_1234;
            bus.flush     = 1'b1;
            bus.stall     = 1'b1;
            @(posedge clk);
            #1;
            check_outputs({tag, ".held"});
        end
        rst = 1'b0;
        $display("%s: reset pulse hold=%0b -> adrs=%h v=%0b halt=%0b cnt=%0d",
                 tag, hold_edge, bus.inst_adrs, bus.ifid_valid, bus.halted, bus.fetch_count);
    endtask

    task automatic fill_plain_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
    endtask

    initial begin
        bus.br_taken  = 1'b0;
        bus.flush     = 1'b0;
        bus.stall     = 1'b0;
        bus.br_target = 32'd0;
        fill_plain_mem();
        mem[6] = HALT_W;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        check_outputs("reset0");
        @(posedge clk);
        #1;
        check_outputs("reset1");
        rst = 1'b0;

        // Sequential fetch of words 0..2
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, "seq", 1'b1);
        check("seq_abs.pc", bus.ifid_pc, 32'd2);
        check("seq_abs.pc_next", bus.ifid_pc_next, 32'd3);
        check("seq_abs.count", {16'd0, bus.fetch_count}, 32'd3);
        check("seq_abs.adrs", bus.inst_adrs, 32'd3);

        // Stall two cycles at PC=4
        step(1'b0, 1'b0, 1'b0, 32'd0, "seq", 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'd0, "stall", 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'd0, "stall", 1'b1);
        check("stall_abs.adrs", bus.inst_adrs, 32'd4);
        check("stall_abs.pc", bus.ifid_pc, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'd0, "resume", 1'b1);
        check("resume_abs.pc", bus.ifid_pc, 32'd4);

        // Word 5, then the halt word at 6
        step(1'b0, 1'b0, 1'b0, 32'd0, "seq", 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, "halt", 1'b1);
        check("halt_abs.halted", {31'd0, bus.halted}, 32'd1);
        check("halt_abs.adrs", bus.inst_adrs, 32'd6);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'd0, "halted", 1'b1);

        // Async reset while halted, held across an edge with everything asserted
        reset_pulse(1'b1, "rst_halt");
        step(1'b0, 1'b0, 1'b0, 32'd0, "post_rst", 1'b1);
        check("post_rst_abs.pc", bus.ifid_pc, RST_PC);

        // Back to halt, then branch out to 0
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0, "to_halt", 1'b1);
        check("rehalt_abs.halted", {31'd0, bus.halted}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, "br_unhalt", 1'b1);
        check("unhalt_abs.halted", {31'd0, bus.halted}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, "after_unhalt", 1'b1);

        // Branch with stall and flush asserted
        step(1'b1, 1'b1, 1'b1, 32'h10, "br_all", 1'b1);
        check("br_all_abs.adrs", bus.inst_adrs, 32'h10);
        check("br_all_abs.valid", {31'd0, bus.ifid_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, "after_br", 1'b1);
        check("after_br_abs.pc", bus.ifid_pc, 32'h10);

        // Async reset while IF/ID is valid
        reset_pulse(1'b0, "rst_valid");
        step(1'b0, 1'b0, 1'b0, 32'd0, "post_rst2", 1'b1);

        // PC wrap
        step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, "br_wrap", 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, "wrap", 1'b1);
        check("wrap_abs.pc_next", bus.ifid_pc_next, 32'd0);
        check("wrap_abs.adrs", bus.inst_adrs, 32'd0);

        // Randomized traffic with halt words sprinkled in memory
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? HALT_W : ($urandom & 32'h7FFF_FFFF);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                @(negedge clk);
                reset_pulse(1'($urandom_range(0, 1)), "rnd_rst");
            end else begin
                logic [31:0] tgt;
                tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                  : 32'($urandom_range(0, 63));
                step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 3) == 0), tgt, "rnd", 1'b1);
            end
        end

        // Counter saturation over a long halt-free run
        fill_plain_mem();
        @(negedge clk);
        reset_pulse(1'b0, "rst_sat");
        for (int n = 0; n < 65540; n++) step(1'b0, 1'b0, 1'b0, 32'd0, "sat", 1'b0);
        check("sat_abs.count", {16'd0, bus.fetch_count}, 32'h0000_FFFF);
        $display("sat: 65540 fetches -> cnt=%0d adrs=%h", bus.fetch_count, bus.inst_adrs);
        step(1'b0, 1'b0, 1'b0, 32'd0, "sat_hold", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
